// File: rtl/player_ctrl.sv
// Player-ship controller: position, lives, level, pause/death/win sequencing, fire requests.
// Optional macro PLAYER_FLASH_EN: blink the ship while in HIT.
//
// Ports:
//   clk_i, reset_i (sync, active high), frame_i (per-frame pulse)
//   move_left_i, move_right_i, shoot_i (button levels)
//   hit_i, level_clear_i (event pulses), bullet_ready_i (bullet engine free)
//   fire_o (1-cycle shot request), pos_left_o/pos_right_o (ship x span)
//   lives_o, level_o, alive_o, paused_o, game_won_o, visible_o, color_o
//   state_o (one-hot state for debug)
module player_ctrl #(
    parameter int          pos_width_p    = 10,
    parameter int          screen_width_p = 640,
    parameter int          ship_width_p   = 32,
    parameter int          step_p         = 2,
    parameter int          start_lives_p  = 2,
    parameter int          max_lives_p    = 3,
    parameter int          num_levels_p   = 8,
    parameter logic [11:0] color_p        = 12'b0110_0000_0101
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic                                 frame_i,
    input  logic                                 move_left_i,
    input  logic                                 move_right_i,
    input  logic                                 shoot_i,
    input  logic                                 hit_i,
    input  logic                                 level_clear_i,
    input  logic                                 bullet_ready_i,
    output logic                                 fire_o,
    output logic [pos_width_p-1:0]               pos_left_o,
    output logic [pos_width_p-1:0]               pos_right_o,
    output logic [$clog2(max_lives_p+1)-1:0]     lives_o,
    output logic [$clog2(num_levels_p+1)-1:0]    level_o,
    output logic                                 alive_o,
    output logic                                 paused_o,
    output logic                                 game_won_o,
    output logic                                 visible_o,
    output logic [11:0]                          color_o,
    output logic [4:0]                           state_o
);

    localparam int LW = $clog2(max_lives_p + 1);
    localparam int VW = $clog2(num_levels_p + 1);
    localparam int PW = pos_width_p;

    localparam logic [PW:0]   MAX_POS   = (PW+1)'(screen_width_p - ship_width_p);
    localparam logic [PW:0]   STEP      = (PW+1)'(step_p);
    localparam logic [PW-1:0] RIGHT_OFF = PW'(ship_width_p - 1);
    localparam logic [PW-1:0] CENTER    = PW'((screen_width_p - ship_width_p) / 2);
    localparam logic [PW-1:0] CENTER_R  = PW'((screen_width_p - ship_width_p) / 2
                                              + ship_width_p - 1);

    localparam logic [LW-1:0] START_LIVES = LW'(start_lives_p);
    localparam logic [LW-1:0] MAX_LIVES   = LW'(max_lives_p);
    localparam logic [LW-1:0] LIVES_ONE   = LW'(1);
    localparam logic [VW-1:0] LAST_LEVEL  = VW'(num_levels_p);
    localparam logic [VW-1:0] LEVEL_ONE   = VW'(1);

`ifdef PLAYER_FLASH_EN
    localparam logic HIT_VIS = 1'b0;
`else
    localparam logic HIT_VIS = 1'b1;
`endif

    typedef enum logic [4:0] {
        S_PLAY       = 5'b00001,
        S_HIT        = 5'b00010,
        S_DEAD       = 5'b00100,
        S_LEVEL_DONE = 5'b01000,
        S_WON        = 5'b10000
    } state_t;

    state_t          r_state;
    logic [PW-1:0]   r_pos;
    logic [PW-1:0]   r_pos_right;
    logic [LW-1:0]   r_lives;
    logic [VW-1:0]   r_level;
    logic            r_fire;
    logic            r_alive;
    logic            r_paused;
    logic            r_won;
    logic            r_visible;
    logic            r_shoot_prev;
`ifdef PLAYER_FLASH_EN
    logic [2:0]      r_flash_cnt;
`endif

    logic            w_shoot_edge;
    logic            w_left_only;
    logic            w_right_only;
    logic [PW:0]     w_pos_ext;
    logic [PW:0]     w_pos_sum;
    logic [PW:0]     w_pos_nxt;

    assign w_shoot_edge = shoot_i & ~r_shoot_prev;
    assign w_left_only  = move_left_i & ~move_right_i;
    assign w_right_only = move_right_i & ~move_left_i;
    assign w_pos_ext    = {1'b0, r_pos};
    assign w_pos_sum    = w_pos_ext + STEP;

    // Saturating move in one extra bit so neither edge can wrap.
    always_comb begin
        w_pos_nxt = w_pos_ext;
        if (frame_i && w_left_only) begin
            w_pos_nxt = (w_pos_ext >= STEP) ? (w_pos_ext - STEP) : '0;
        end else if (frame_i && w_right_only) begin
            w_pos_nxt = (w_pos_sum > MAX_POS) ? MAX_POS : w_pos_sum;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state      <= S_PLAY;
            r_pos        <= CENTER;
            r_pos_right  <= CENTER_R;
            r_lives      <= START_LIVES;
            r_level      <= LEVEL_ONE;
            r_fire       <= 1'b0;
            r_alive      <= 1'b1;
            r_paused     <= 1'b0;
            r_won        <= 1'b0;
            r_visible    <= 1'b1;
            r_shoot_prev <= 1'b1;
`ifdef PLAYER_FLASH_EN
            r_flash_cnt  <= '0;
`endif
        end else begin
            r_shoot_prev <= shoot_i;
            r_fire       <= 1'b0;
            unique case (r_state)
                S_PLAY: begin
                    r_pos       <= w_pos_nxt[PW-1:0];
                    r_pos_right <= w_pos_nxt[PW-1:0] + RIGHT_OFF;
                    r_fire      <= w_shoot_edge & bullet_ready_i;
                    // hit wins over a simultaneous level clear
                    if (hit_i) begin
                        if (r_lives > LIVES_ONE) begin
                            r_lives   <= r_lives - LIVES_ONE;
                            r_state   <= S_HIT;
                            r_paused  <= 1'b1;
                            r_visible <= HIT_VIS;
`ifdef PLAYER_FLASH_EN
                            r_flash_cnt <= '0;
`endif
                        end else begin
                            r_lives   <= '0;
                            r_state   <= S_DEAD;
                            r_alive   <= 1'b0;
                            r_visible <= 1'b0;
                        end
                    end else if (level_clear_i) begin
                        if (r_level == LAST_LEVEL) begin
                            r_state <= S_WON;
                            r_won   <= 1'b1;
                        end else begin
                            r_state  <= S_LEVEL_DONE;
                            r_paused <= 1'b1;
                            // bonus life after clearing an even level
                            if (!r_level[0] && r_lives < MAX_LIVES) begin
                                r_lives <= r_lives + LIVES_ONE;
                            end
                        end
                    end
                end
                S_HIT: begin
                    if (w_shoot_edge) begin
                        r_pos       <= CENTER;
                        r_pos_right <= CENTER_R;
                        r_state     <= S_PLAY;
                        r_paused    <= 1'b0;
                        r_visible   <= 1'b1;
`ifdef PLAYER_FLASH_EN
                    end else if (frame_i) begin
                        r_flash_cnt <= r_flash_cnt + 3'd1;
                        if (r_flash_cnt == 3'd7) begin
                            r_visible <= ~r_visible;
                        end
`endif
                    end
                end
                S_LEVEL_DONE: begin
                    if (w_shoot_edge) begin
                        r_level     <= r_level + LEVEL_ONE;
                        r_pos       <= CENTER;
                        r_pos_right <= CENTER_R;
                        r_state     <= S_PLAY;
                        r_paused    <= 1'b0;
                    end
                end
                S_DEAD: begin
                    if (w_shoot_edge) begin
                        r_lives     <= START_LIVES;
                        r_level     <= LEVEL_ONE;
                        r_pos       <= CENTER;
                        r_pos_right <= CENTER_R;
                        r_state     <= S_PLAY;
                        r_alive     <= 1'b1;
                        r_visible   <= 1'b1;
                    end
                end
                S_WON: begin
                end
                default: begin
                    r_state <= S_PLAY;
                end
            endcase
        end
    end

    assign fire_o      = r_fire;
    assign pos_left_o  = r_pos;
    assign pos_right_o = r_pos_right;
    assign lives_o     = r_lives;
    assign level_o     = r_level;
    assign alive_o     = r_alive;
    assign paused_o    = r_paused;
    assign game_won_o  = r_won;
    assign visible_o   = r_visible;
    assign color_o     = color_p;
    assign state_o     = r_state;

endmodule

// File: tb/tb_player_ctrl.sv
// Testbench for player_ctrl: directed scenarios plus random play,
// every cycle compared against a behavioural game model.
module tb_player_ctrl;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        frame_i = 1'b0;
    logic        move_left_i = 1'b0;
    logic        move_right_i = 1'b0;
    logic        shoot_i = 1'b0;
    logic        hit_i = 1'b0;
    logic        level_clear_i = 1'b0;
    logic        bullet_ready_i = 1'b0;
    logic        fire_o;
    logic [9:0]  pos_left_o;
    logic [9:0]  pos_right_o;
    logic [1:0]  lives_o;
    logic [3:0]  level_o;
    logic        alive_o;
    logic        paused_o;
    logic        game_won_o;
    logic        visible_o;
    logic [11:0] color_o;
    logic [4:0]  state_o;

    player_ctrl dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .frame_i        (frame_i),
        .move_left_i    (move_left_i),
        .move_right_i   (move_right_i),
        .shoot_i        (shoot_i),
        .hit_i          (hit_i),
        .level_clear_i  (level_clear_i),
        .bullet_ready_i (bullet_ready_i),
        .fire_o         (fire_o),
        .pos_left_o     (pos_left_o),
        .pos_right_o    (pos_right_o),
        .lives_o        (lives_o),
        .level_o        (level_o),
        .alive_o        (alive_o),
        .paused_o       (paused_o),
        .game_won_o     (game_won_o),
        .visible_o      (visible_o),
        .color_o        (color_o),
        .state_o        (state_o)
    );

    always #5 clk_i = ~clk_i;

    // game modes; debug code is 1 << mode
    localparam int M_PLAY = 0;
    localparam int M_HIT  = 1;
    localparam int M_DEAD = 2;
    localparam int M_LD   = 3;
    localparam int M_WON  = 4;

    int n_checks = 0;
    int n_errors = 0;
    int fire_seen = 0;

    int m_mode;
    int m_pos;
    int m_lives;
    int m_level;
    int m_fire;
    bit m_prev;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_step();
        bit edge_s;
        if (reset_i) begin
            m_mode  = M_PLAY;
            m_pos   = 304;
            m_lives = 2;
            m_level = 1;
            m_fire  = 0;
            m_prev  = 1'b1;
        end else begin
            edge_s = shoot_i && !m_prev;
            m_prev = shoot_i;
            m_fire = 0;
            case (m_mode)
                M_PLAY: begin
                    if (frame_i && move_left_i && !move_right_i)
                        m_pos = (m_pos - 2 < 0) ? 0 : m_pos - 2;
                    if (frame_i && move_right_i && !move_left_i)
                        m_pos = (m_pos + 2 > 608) ? 608 : m_pos + 2;
                    m_fire = (edge_s && bullet_ready_i) ? 1 : 0;
                    if (hit_i) begin
                        if (m_lives > 1) begin
                            m_lives--;
                            m_mode = M_HIT;
                        end else begin
                            m_lives = 0;
                            m_mode = M_DEAD;
                        end
                    end else if (level_clear_i) begin
                        if (m_level == 8) begin
                            m_mode = M_WON;
                        end else begin
                            m_mode = M_LD;
                            if (m_level % 2 == 0 && m_lives < 3) m_lives++;
                        end
                    end
                end
                M_HIT: if (edge_s) begin
                    m_pos = 304;
                    m_mode = M_PLAY;
                end
                M_LD: if (edge_s) begin
                    m_level++;
                    m_pos = 304;
                    m_mode = M_PLAY;
                end
                M_DEAD: if (edge_s) begin
                    m_lives = 2;
                    m_level = 1;
                    m_pos = 304;
                    m_mode = M_PLAY;
                end
                default: ;
            endcase
        end
    endtask

    // advance one clock and compare every output against the model
    task automatic cyc();
        model_step();
        @(posedge clk_i);
        #1;
        fire_seen += int'(fire_o);
        check("fire", 32'(fire_o), 32'(m_fire));
        check("pos_left", 32'(pos_left_o), 32'(m_pos));
        check("pos_right", 32'(pos_right_o), 32'(m_pos + 31));
        check("lives", 32'(lives_o), 32'(m_lives));
        check("level", 32'(level_o), 32'(m_level));
        check("alive", 32'(alive_o), 32'(m_lives > 0));
        check("paused", 32'(paused_o), 32'(m_mode == M_HIT || m_mode == M_LD));
        check("won", 32'(game_won_o), 32'(m_mode == M_WON));
        check("visible", 32'(visible_o), 32'(m_mode != M_DEAD));
        check("color", 32'(color_o), 32'h605);
        check("state", 32'(state_o), 32'(1 << m_mode));
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        cyc();
        reset_i = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame_i = 1'b1;
            cyc();
            frame_i = 1'b0;
            cyc();
        end
    endtask

    task automatic shoot_edge();
        shoot_i = 1'b0;
        cyc();
        shoot_i = 1'b1;
        cyc();
        shoot_i = 1'b0;
        cyc();
    endtask

    task automatic pulse_hit();
        hit_i = 1'b1;
        cyc();
        hit_i = 1'b0;
    endtask

    task automatic pulse_clear();
        level_clear_i = 1'b1;
        cyc();
        level_clear_i = 1'b0;
    endtask

    initial begin
        // reset values
        shoot_i = 1'b1;
        do_reset();
        check("rst_pos", 32'(pos_left_o), 32'd304);
        check("rst_state", 32'(state_o), 32'b00001);
        check("rst_lives", 32'(lives_o), 32'd2);
        cyc();
        check("held_no_fire", 32'(fire_o), 32'd0);
        shoot_i = 1'b0;

        // left movement and saturation at 0
        move_left_i = 1'b1;
        frames(5);
        check("left5", 32'(pos_left_o), 32'd294);
        check("left5_r", 32'(pos_right_o), 32'd325);
        frames(200);
        check("left_sat", 32'(pos_left_o), 32'd0);
        move_left_i = 1'b0;

        // right movement, saturation, both-held hold
        move_right_i = 1'b1;
        frames(400);
        check("right_sat", 32'(pos_left_o), 32'd608);
        check("right_sat_r", 32'(pos_right_o), 32'd639);
        move_left_i = 1'b1;
        frames(5);
        check("both_hold", 32'(pos_left_o), 32'd608);
        move_left_i = 1'b0;
        move_right_i = 1'b0;

        // fire: one pulse per edge, none when bullet busy
        bullet_ready_i = 1'b1;
        fire_seen = 0;
        shoot_i = 1'b1;
        for (int i = 0; i < 10; i++) cyc();
        shoot_i = 1'b0;
        cyc();
        check("one_fire", 32'(fire_seen), 32'd1);
        bullet_ready_i = 1'b0;
        fire_seen = 0;
        shoot_i = 1'b1;
        for (int i = 0; i < 3; i++) cyc();
        shoot_i = 1'b0;
        cyc();
        check("busy_nofire", 32'(fire_seen), 32'd0);

        // hit, recover, die, restart
        do_reset();
        pulse_hit();
        check("hit_state", 32'(state_o), 32'b00010);
        check("hit_lives", 32'(lives_o), 32'd1);
        check("hit_paused", 32'(paused_o), 32'd1);
        shoot_edge();
        check("resume_state", 32'(state_o), 32'b00001);
        check("resume_pos", 32'(pos_left_o), 32'd304);
        pulse_hit();
        check("dead_alive", 32'(alive_o), 32'd0);
        check("dead_vis", 32'(visible_o), 32'd0);
        shoot_edge();
        check("restart_lives", 32'(lives_o), 32'd2);
        check("restart_level", 32'(level_o), 32'd1);

        // level clear bonus and hit priority
        do_reset();
        pulse_clear();
        shoot_edge();
        check("level2", 32'(level_o), 32'd2);
        pulse_clear();
        check("ld_state", 32'(state_o), 32'b01000);
        check("bonus_life", 32'(lives_o), 32'd3);
        shoot_edge();
        check("level3", 32'(level_o), 32'd3);
        hit_i = 1'b1;
        level_clear_i = 1'b1;
        cyc();
        hit_i = 1'b0;
        level_clear_i = 1'b0;
        check("prio_state", 32'(state_o), 32'b00010);
        check("prio_level", 32'(level_o), 32'd3);

        // win and hold until reset
        do_reset();
        for (int l = 1; l < 8; l++) begin
            pulse_clear();
            shoot_edge();
        end
        check("level8", 32'(level_o), 32'd8);
        pulse_clear();
        check("won", 32'(game_won_o), 32'd1);
        check("won_state", 32'(state_o), 32'b10000);
        shoot_edge();
        pulse_hit();
        pulse_clear();
        check("won_hold", 32'(state_o), 32'b10000);
        do_reset();
        check("post_won_state", 32'(state_o), 32'b00001);
        check("post_won_level", 32'(level_o), 32'd1);
        check("post_won_won", 32'(game_won_o), 32'd0);

        // random play against the model
        for (int i = 0; i < 20000; i++) begin
            frame_i        = ($urandom_range(3) == 0);
            bullet_ready_i = ($urandom_range(2) != 0);
            hit_i          = ($urandom_range(40) == 0);
            level_clear_i  = ($urandom_range(20) == 0);
            reset_i        = ($urandom_range(800) == 0);
            if ($urandom_range(15) == 0) move_left_i = $urandom_range(1) != 0;
            if ($urandom_range(15) == 0) move_right_i = $urandom_range(1) != 0;
            if ($urandom_range(3) == 0) shoot_i = ~shoot_i;
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/player_ctrl.md
Name: player_ctrl

Overview:
Parametrised player-ship controller for the space-invaders datapath. Owns the ship position, lives, level number, pause/death/win sequencing and fire requests to the bullet engine. Movement is frame-paced by a frame tick from the video timing block. All outputs are registered.

Parameters:
pos_width_p, 10, width of horizontal position busses
screen_width_p, 640, playfield width in pixels
ship_width_p, 32, ship width in pixels
step_p, 2, pixels moved per frame tick
start_lives_p, 2, lives after reset or restart
max_lives_p, 3, lives ceiling
num_levels_p, 8, final level number
color_p, 12'b0110_0000_0101, ship RGB passed to color_o

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
frame_i  in  1  one-cycle pulse per video frame
move_left_i  in  1  left button level
move_right_i  in  1  right button level
shoot_i  in  1  shoot/resume button level
hit_i  in  1  player hit by enemy bullet (pulse)
level_clear_i  in  1  all enemies destroyed (pulse)
bullet_ready_i  in  1  bullet engine can accept a shot
fire_o  out  1  one-cycle fire request
pos_left_o  out  pos_width_p  ship left x
pos_right_o  out  pos_width_p  ship right x (left + ship_width_p - 1)
lives_o  out  clog2(max_lives_p+1)  lives remaining
level_o  out  clog2(num_levels_p+1)  current level, 1-based
alive_o  out  1  lives_o > 0
paused_o  out  1  state is HIT or LEVEL_DONE
game_won_o  out  1  state is WON
visible_o  out  1  draw enable for ship
color_o  out  12  color_p
state_o  out  5  one-hot state for debug

Behaviour:
- Reset: state PLAY, pos_left_o = (screen_width_p - ship_width_p)/2 (304 at defaults), lives_o = start_lives_p, level_o = 1, fire_o = 0, alive_o = 1, paused_o = 0, game_won_o = 0, visible_o = 1.
- shoot_i is edge-detected via a registered previous value. The edge register resets to 1 so a held button does not fire after reset.
- States, one-hot: PLAY=00001, HIT=00010, DEAD=00100, LEVEL_DONE=01000, WON=10000.
- PLAY:
  - On frame_i, left only: pos = max(0, pos - step_p). Right only: pos = min(screen_width_p - ship_width_p, pos + step_p). Both or neither: hold.
  - Saturate without wrap; compute in pos_width_p+1 bits.
  - Shoot edge with bullet_ready_i = 1: fire_o pulses one cycle later. Edge with bullet_ready_i = 0 is dropped, not queued.
- hit_i in PLAY:
  - lives > 1: lives decrement, go to HIT.
  - lives = 1: lives become 0, go to DEAD.
- level_clear_i in PLAY:
  - level = num_levels_p: go to WON.
  - Otherwise go to LEVEL_DONE. If level is even and lives < max_lives_p, lives increment.
- Simultaneous hit_i and level_clear_i: hit has priority and level_clear is ignored.
- HIT: position frozen, hit_i and level_clear_i ignored. Shoot edge: pos recentred, go to PLAY, no fire_o.
- LEVEL_DONE: shoot edge increments level, recentres pos, goes to PLAY.
- DEAD: shoot edge restarts the game. lives = start_lives_p, level = 1, pos centred, go to PLAY.
- WON: held until reset_i. All inputs ignored.
- Movement and fire occur only in PLAY.
- reset_i has priority over every event in the same cycle.
- Mid-operation reset returns all state to reset values on the next edge.

Optional Feature:
PLAYER_FLASH_EN
- Defined: in HIT, visible_o toggles every 8 frame_i pulses, starting at 0 on HIT entry. visible_o returns to 1 on leaving HIT.
- Undefined: visible_o = 1 in all states except DEAD, where it is 0.

Test Plan:
- Reset, hold move_left_i for 5 frame_i pulses -> pos_left_o 294, pos_right_o 325. Hold 200 more -> pos_left_o saturates at 0, no wrap.
- Hold move_right_i for 400 frames -> pos_left_o = 608, pos_right_o = 639. Both buttons held -> position unchanged.
- Shoot edge with bullet_ready_i = 1 -> single fire_o pulse. Shoot held for 10 cycles -> still one pulse. Edge with bullet_ready_i = 0 -> no pulse.
- Reset, hit_i -> HIT, lives_o 1, paused_o 1. Shoot edge -> PLAY, pos 304. hit_i again -> DEAD, alive_o 0, visible_o 0. Shoot edge -> lives_o 2, level_o 1.
- level_clear_i at level 2 with lives 2 -> LEVEL_DONE, lives_o 3. Shoot edge -> level_o 3. hit_i and level_clear_i in same cycle -> HIT, level unchanged.
- Clear all 8 levels -> game_won_o 1, state_o 10000. Shoot/hit ignored until reset_i. reset_i -> all reset values.
